// File: rtl/iob_eth_frame_port_if.sv
// CPU-side frame handshakes and MAC buffer-memory strobes of the byte-wise frame port.
interface iob_eth_frame_port_if #(
   parameter int BUFFER_W = 11
);
   logic                tx_start_i;
   logic [BUFFER_W-1:0] tx_len_i;
   logic                tx_wvalid_i;
   logic [7:0]          tx_wdata_i;
   logic                tx_wready_o;
   logic                tx_ram_we_o;
   logic [BUFFER_W-1:0] tx_ram_addr_o;
   logic [7:0]          tx_ram_wdata_o;
   logic                tx_frame_ready_o;
   logic                tx_done_i;
   logic                rx_frame_valid_i;
   logic [BUFFER_W-1:0] rx_len_i;
   logic [BUFFER_W-1:0] rx_nbytes_o;
   logic                rx_rreq_i;
   logic                rx_rready_o;
   logic                rx_rvalid_o;
   logic [7:0]          rx_rdata_o;
   logic                rx_ram_re_o;
   logic [BUFFER_W-1:0] rx_ram_addr_o;
   logic [7:0]          rx_ram_rdata_i;
   logic                rx_release_o;
   logic                rx_overrun_o;

   modport slave (
      input  tx_start_i, tx_len_i, tx_wvalid_i, tx_wdata_i, tx_done_i,
             rx_frame_valid_i, rx_len_i, rx_rreq_i, rx_ram_rdata_i,
      output tx_wready_o, tx_ram_we_o, tx_ram_addr_o, tx_ram_wdata_o, tx_frame_ready_o,
             rx_nbytes_o, rx_rready_o, rx_rvalid_o, rx_rdata_o, rx_ram_re_o,
             rx_ram_addr_o, rx_release_o, rx_overrun_o
   );

   modport master (
      output tx_start_i, tx_len_i, tx_wvalid_i, tx_wdata_i, tx_done_i,
             rx_frame_valid_i, rx_len_i, rx_rreq_i, rx_ram_rdata_i,
      input  tx_wready_o, tx_ram_we_o, tx_ram_addr_o, tx_ram_wdata_o, tx_frame_ready_o,
             rx_nbytes_o, rx_rready_o, rx_rvalid_o, rx_rdata_o, rx_ram_re_o,
             rx_ram_addr_o, rx_release_o, rx_overrun_o
   );
endinterface

// File: rtl/iob_eth_frame_port.sv
// Byte-wise frame port: fills the TX buffer from CPU writes and streams the RX buffer back on CPU reads.
//
// state   | meaning
// TX_IDLE | no TX frame in progress, waiting for a start with nonzero length
// TX_FILL | accepting CPU bytes into the TX buffer
// TX_WAIT | frame stored, MAC transmitting, waiting for done
// RX_IDLE | RX buffer empty
// RX_HOLD | frame pending, waiting for a CPU read request
// RX_RD   | buffer byte returning to the CPU this cycle
module iob_eth_frame_port #(
   parameter int BUFFER_W = 11
) (
   input  logic                  clk_i,
   input  logic                  cke_i,
   input  logic                  rst_i,
   iob_eth_frame_port_if.slave   port_if
);
   typedef enum logic [1:0] {TX_IDLE, TX_FILL, TX_WAIT} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_HOLD, RX_RD} rx_state_t;

   tx_state_t           r_tx_state;
   rx_state_t           r_rx_state;
   logic [BUFFER_W-1:0] r_tx_len;
   logic [BUFFER_W-1:0] r_tx_cnt;
   logic [BUFFER_W-1:0] r_tx_addr;
   logic [7:0]          r_tx_wdata;
   logic                r_tx_we;
   logic [BUFFER_W-1:0] r_rx_len;
   logic [BUFFER_W-1:0] r_rx_cnt;

   logic w_tx_wready;
   logic w_tx_acc;
   logic w_tx_last;
   logic w_rx_rready;
   logic w_rx_acc;
   logic w_rx_rd;
   logic w_rx_last;
   logic w_rx_new;

   // Handshakes are gated by cke_i so nothing is accepted while state is frozen.
   assign w_tx_wready = cke_i & (r_tx_state == TX_FILL);
   assign w_tx_acc    = port_if.tx_wvalid_i & w_tx_wready;
   assign w_tx_last   = (r_tx_cnt == r_tx_len - BUFFER_W'(1));
   assign w_rx_rready = cke_i & (r_rx_state == RX_HOLD);
   assign w_rx_acc    = port_if.rx_rreq_i & w_rx_rready;
   assign w_rx_rd     = cke_i & (r_rx_state == RX_RD);
   assign w_rx_last   = (r_rx_cnt == r_rx_len - BUFFER_W'(1));
   assign w_rx_new    = port_if.rx_frame_valid_i & (port_if.rx_len_i != '0);

   assign port_if.tx_wready_o      = w_tx_wready;
   assign port_if.tx_ram_we_o      = r_tx_we & cke_i;
   assign port_if.tx_ram_addr_o    = r_tx_addr;
   assign port_if.tx_ram_wdata_o   = r_tx_wdata;
   assign port_if.tx_frame_ready_o = (r_tx_state == TX_WAIT);

   assign port_if.rx_nbytes_o   = (r_rx_state == RX_HOLD || r_rx_state == RX_RD) ? r_rx_len : '0;
   assign port_if.rx_rready_o   = w_rx_rready;
   assign port_if.rx_rvalid_o   = w_rx_rd;
   assign port_if.rx_rdata_o    = w_rx_rd ? port_if.rx_ram_rdata_i : 8'h00;
   assign port_if.rx_ram_re_o   = w_rx_acc;
   assign port_if.rx_ram_addr_o = r_rx_cnt;
   assign port_if.rx_release_o  = w_rx_rd & w_rx_last;
   assign port_if.rx_overrun_o  = cke_i & w_rx_new & (r_rx_state != RX_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_state <= TX_IDLE;
         r_tx_len   <= '0;
         r_tx_cnt   <= '0;
         r_tx_addr  <= '0;
         r_tx_wdata <= '0;
         r_tx_we    <= 1'b0;
         r_rx_state <= RX_IDLE;
         r_rx_len   <= '0;
         r_rx_cnt   <= '0;
      end else if (cke_i) begin
         r_tx_we <= w_tx_acc;
         if (w_tx_acc) begin
            r_tx_addr  <= r_tx_cnt;
            r_tx_wdata <= port_if.tx_wdata_i;
         end
         case (r_tx_state)
            TX_IDLE: if (port_if.tx_start_i && port_if.tx_len_i != '0) begin
               r_tx_len   <= port_if.tx_len_i;
               r_tx_cnt   <= '0;
               r_tx_state <= TX_FILL;
            end
            TX_FILL: if (w_tx_acc) begin
               r_tx_cnt <= r_tx_cnt + BUFFER_W'(1);
               if (w_tx_last) r_tx_state <= TX_WAIT;
            end
            TX_WAIT: if (port_if.tx_done_i) r_tx_state <= TX_IDLE;
            default: r_tx_state <= TX_IDLE;
         endcase

         case (r_rx_state)
            RX_IDLE: if (w_rx_new) begin
               r_rx_len   <= port_if.rx_len_i;
               r_rx_cnt   <= '0;
               r_rx_state <= RX_HOLD;
            end
            RX_HOLD: if (w_rx_acc) r_rx_state <= RX_RD;
            RX_RD: begin
               r_rx_cnt   <= r_rx_cnt + BUFFER_W'(1);
               r_rx_state <= w_rx_last ? RX_IDLE : RX_HOLD;
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: doc/iob_eth_frame_port.md
# iob_eth_frame_port

Non-DMA byte-wise frame port of the IOb ethernet core, sitting between the CSR bank's FRAME_WORD / RX_NBYTES registers and the MAC's TX/RX buffer memories. It feeds CPU-written bytes into the TX buffer and signals the MAC when a full frame of the programmed length is stored. It exposes received frame length to the CPU, streams RX buffer bytes back on CPU read requests, and releases the RX buffer after the last byte. This is the hardware path exercised by software and simulation drivers that poll `RX_NBYTES` and push or pull frames one byte at a time.

## Interface
- `BUFFER_W`, 11: byte address width of each buffer; maximum frame length is 2^BUFFER_W-1.
- `clk_i` in 1: clock.
- `cke_i` in 1: clock enable; when low, all state holds and `tx_ram_we_o`, `rx_ram_re_o`, `rx_release_o` and `rx_overrun_o` are low.
- `rst_i` in 1: reset, synchronous, active-high.
- `tx_start_i` in 1: pulse; the CPU set the TX buffer descriptor ready bit.
- `tx_len_i` in BUFFER_W: TX frame length, sampled on `tx_start_i`.
- `tx_wvalid_i` in 1: CPU FRAME_WORD write.
- `tx_wdata_i` in 8: frame byte.
- `tx_wready_o` out 1: byte accepted when `tx_wvalid_i & tx_wready_o`.
- `tx_ram_we_o` out 1: TX buffer write strobe.
- `tx_ram_addr_o` out BUFFER_W: TX buffer write address.
- `tx_ram_wdata_o` out 8: TX buffer write data.
- `tx_frame_ready_o` out 1: full frame stored; level signal to the MAC.
- `tx_done_i` in 1: pulse; the MAC finished transmission.
- `rx_frame_valid_i` in 1: pulse; the MAC stored a good frame.
- `rx_len_i` in BUFFER_W: RX frame length, sampled with `rx_frame_valid_i`.
- `rx_nbytes_o` out BUFFER_W: pending RX frame length; 0 means no frame.
- `rx_rreq_i` in 1: CPU FRAME_WORD read request.
- `rx_rready_o` out 1: read request accepted when `rx_rreq_i & rx_rready_o`.
- `rx_rvalid_o` out 1: `rx_rdata_o` is valid.
- `rx_rdata_o` out 8: RX byte.
- `rx_ram_re_o` out 1: RX buffer read strobe.
- `rx_ram_addr_o` out BUFFER_W: RX buffer read address.
- `rx_ram_rdata_i` in 8: RX buffer data, returned 1 cycle after `rx_ram_re_o`.
- `rx_release_o` out 1: pulse; the RX buffer is free and the MAC may set the BD empty.
- `rx_overrun_o` out 1: pulse; a frame was signalled while one was still pending and was dropped.

## Operation
- The TX and RX paths are independent FSMs. Simultaneous TX and RX events are both serviced in the same cycle.
- **TX FSM: TX_IDLE -> TX_FILL -> TX_WAIT -> TX_IDLE**
  - In TX_IDLE, `tx_start_i` with a nonzero `tx_len_i` latches the length, clears `tx_cnt` and moves to TX_FILL.
  - In TX_IDLE, `tx_len_i == 0` is ignored.
  - `tx_start_i` outside TX_IDLE is ignored.
  - In TX_FILL, `tx_wready_o = 1`. Each accepted byte is written to address `tx_cnt`, then `tx_cnt` increments.
  - The accepted byte with `tx_cnt == len-1` moves the FSM to TX_WAIT.
  - In TX_WAIT, `tx_frame_ready_o = 1`. `tx_done_i` returns the FSM to TX_IDLE.
  - `tx_wvalid_i` outside TX_FILL is dropped; the bench checks that no RAM write occurs.
- **RX FSM: RX_IDLE -> RX_HOLD <-> RX_RD -> RX_IDLE**
  - In RX_IDLE, `rx_frame_valid_i` with a nonzero `rx_len_i` latches the length, clears `rx_cnt` and moves to RX_HOLD.
  - `rx_nbytes_o` equals the latched length in RX_HOLD and RX_RD, and 0 otherwise.
  - In RX_HOLD, `rx_rready_o = 1`. An accepted request asserts `rx_ram_re_o` with `rx_ram_addr_o = rx_cnt` and moves to RX_RD.
  - In RX_RD, `rx_rready_o = 0`, `rx_rvalid_o = 1` and `rx_rdata_o = rx_ram_rdata_i`; `rx_cnt` increments.
  - From RX_RD, if `rx_cnt` was len-1, `rx_release_o` pulses and the FSM moves to RX_IDLE; otherwise it returns to RX_HOLD.
  - `rx_frame_valid_i` while not in RX_IDLE is dropped and pulses `rx_overrun_o`. A zero-length frame is ignored.
- Counters are BUFFER_W bits and never wrap, because lengths are at most 2^BUFFER_W-1.

## Timing
- Reset values: all outputs 0, both FSMs in IDLE, counters 0.
- A reset mid-frame aborts the frame with no release or ready pulse.
- TX RAM write is registered: `tx_ram_we_o`, `tx_ram_addr_o` and `tx_ram_wdata_o` appear 1 cycle after acceptance.
- `tx_frame_ready_o` rises in the same cycle as the write of the last byte.
- TX throughput is 1 byte per cycle.
- `rx_ram_re_o` and `rx_ram_addr_o` are combinational from `rx_rreq_i & rx_rready_o`.
- `rx_rvalid_o` follows 1 cycle after acceptance; read latency is 1 cycle.
- RX throughput is 1 byte per 2 cycles.
- `rx_release_o` is coincident with the last `rx_rvalid_o`. `rx_nbytes_o` reads 0 from the next cycle.
- A TX_WAIT -> TX_IDLE transition caused by `tx_done_i` accepts `tx_start_i` no earlier than the following cycle.

## Test plan
- **TX frame:** start with len=4, write 0xAA, 0xBB, 0xCC, 0xDD back-to-back.
  - Expect 4 RAM writes at addr 0..3 with matching data.
  - Expect `tx_frame_ready_o = 1` in the last-write cycle, held until `tx_done_i`.
  - An extra write before `tx_done_i` produces no RAM write.
- **RX frame:** `rx_frame_valid_i` with len=3 and a RAM model holding 0x11, 0x22, 0x33, with continuous `rx_rreq_i`.
  - `rx_nbytes_o` reads 3.
  - Reads issue at addr 0..2, one every 2 cycles, returning bytes 0x11, 0x22, 0x33.
  - `rx_release_o` pulses with 0x33, then `rx_nbytes_o` reads 0.
- **Overrun:** a second `rx_frame_valid_i` (len=7) while the first frame is in RX_HOLD.
  - `rx_overrun_o` pulses once.
  - `rx_nbytes_o` stays at the original length.
- **Zero length:** `tx_start_i` with len=0 and `rx_frame_valid_i` with len=0 leave both FSMs idle; `tx_wready_o` stays 0.
- **Reset mid-frame:** `rst_i` after 2 of 5 TX bytes.
  - All outputs read 0 the next cycle.
  - A new frame with len=2 then completes normally.
- **Concurrency and enable:** TX and RX frames run simultaneously with `cke_i` toggled low for 3 cycles mid-frame.
  - Both complete with correct data and addresses.
  - No strobes occur while `cke_i` is low.
